// File: rtl/llc_read_arbiter.sv
// Round-robin arbiter sharing one LLC read port among NUM_REQ requesters.
// One outstanding request; address held on the LLC port until it reports a hit.
module llc_read_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int OWN_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [64*NUM_REQ-1:0]  rq_addr,
  input  logic [NUM_REQ-1:0]     rq_valid,
  output logic [511:0]           rq_data,
  output logic [NUM_REQ-1:0]     rq_data_valid,
  output logic [63:0]            llc_addr,
  output logic                   llc_addr_valid,
  input  logic [511:0]           llc_data,
  input  logic                   llc_data_valid,
  output logic                   busy,
  output logic [OWN_W-1:0]       owner,
  output logic                   err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] last_q, last_d;
  logic [OWN_W-1:0] win_idx;
  logic             win_found;
  logic [63:0]      addr_q, addr_d;
  logic [511:0]     data_q, data_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             err_q, err_d;

  // first pending requester after the last grant, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && rq_valid[(int'(last_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = OWN_W'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = WAIT;
          owner_d = win_idx;
          last_d  = win_idx;
          addr_d  = rq_addr[int'(win_idx)*64 +: 64];
          wcnt_d  = '0;
        end
      end
      WAIT: begin
        if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == CNT_W'(TIMEOUT_CYCLES)) err_d = 1'b1;
        if (llc_data_valid) begin
          data_d  = llc_data;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OWN_W'(NUM_REQ - 1);
      addr_q  <= '0;
      data_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    rq_data_valid = '0;
    if (state_q == RESP) rq_data_valid[owner_q] = 1'b1;
  end

  assign rq_data        = data_q;
  assign llc_addr       = addr_q;
  assign llc_addr_valid = (state_q == WAIT);
  assign busy           = (state_q != IDLE);
  assign owner          = owner_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_llc_read_arbiter.sv
// Randomized bench for llc_read_arbiter against a cycle-level
// transaction model of the arbitration and response rules.
module tb_llc_read_arbiter;

  localparam int N = 3;
  localparam int T = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [64*N-1:0] rq_addr;
  logic [N-1:0]   rq_valid;
  logic [511:0]   rq_data;
  logic [N-1:0]   rq_data_valid;
  logic [63:0]    llc_addr;
  logic           llc_addr_valid;
  logic [511:0]   llc_data;
  logic           llc_data_valid;
  logic           busy;
  logic [1:0]     owner;
  logic           err_timeout;

  logic [63:0]    ra [N];

  always #5 clk = ~clk;

  always_comb begin
    rq_addr = '0;
    for (int i = 0; i < N; i++) rq_addr[i*64 +: 64] = ra[i];
  end

  llc_read_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rq_addr(rq_addr),
    .rq_valid(rq_valid),
    .rq_data(rq_data),
    .rq_data_valid(rq_data_valid),
    .llc_addr(llc_addr),
    .llc_addr_valid(llc_addr_valid),
    .llc_data(llc_data),
    .llc_data_valid(llc_data_valid),
    .busy(busy),
    .owner(owner),
    .err_timeout(err_timeout)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t obs=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  // reference model: phase 0=idle, 1=waiting on LLC, 2=returning line
  int           m_ph;
  int           m_last;
  int           m_own;
  int           m_wn;
  bit           m_err;
  logic [63:0]  m_addr;
  logic [511:0] m_data;

  // stimulus knobs
  logic [N-1:0] req_mask;
  int           req_pct, keep_pct, chg_pct, hit_pct;
  bit           fixed_addr;
  logic [63:0]  base [N];
  bit           chk_en = 0;

  function automatic logic [63:0] new_addr(input int i);
    return fixed_addr ? base[i] : {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_ph   = 0;
    m_last = N - 1;
    m_own  = 0;
    m_wn   = 0;
    m_err  = 0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic model_step();
    int win;
    if (reset) begin
      model_reset();
      return;
    end
    case (m_ph)
      0: begin
        win = -1;
        for (int k = 1; k <= N; k++)
          if (win < 0 && rq_valid[(m_last + k) % N]) win = (m_last + k) % N;
        if (win >= 0) begin
          m_own  = win;
          m_last = win;
          m_addr = ra[win];
          m_wn   = 0;
          m_ph   = 1;
        end
      end
      1: begin
        if (m_wn == T) m_err = 1;
        m_wn++;
        if (llc_data_valid) begin
          m_data = llc_data;
          m_ph   = 2;
        end
      end
      default: m_ph = 0;
    endcase
  endtask

  task automatic drive(input bit rst);
    reset = rst;
    for (int i = 0; i < N; i++) begin
      if (rq_valid[i]) begin
        if (m_ph == 2 && m_own == i && $urandom_range(99) >= keep_pct)
          rq_valid[i] = 1'b0;
        else if (m_ph == 1 && $urandom_range(99) < chg_pct)
          ra[i] = {$urandom, $urandom};
      end else if (req_mask[i] && $urandom_range(99) < req_pct) begin
        rq_valid[i] = 1'b1;
        ra[i] = new_addr(i);
      end
    end
    llc_data_valid = ($urandom_range(99) < hit_pct);
    for (int w = 0; w < 16; w++) llc_data[w*32 +: 32] = $urandom;
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_dv;
    e_dv = '0;
    if (m_ph == 2) e_dv[m_own] = 1'b1;
    chk("busy", 512'(busy), 512'(m_ph != 0));
    chk("llc_addr_valid", 512'(llc_addr_valid), 512'(m_ph == 1));
    chk("llc_addr", 512'(llc_addr), 512'(m_addr));
    chk("rq_data_valid", 512'(rq_data_valid), 512'(e_dv));
    chk("rq_data", rq_data, m_data);
    chk("owner", 512'(owner), 512'(m_own));
    chk("err_timeout", 512'(err_timeout), 512'(m_err));
  endtask

  task automatic run(input int n, input bit rst);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      drive(rst);
      #1;
      if (chk_en) check_outputs();
      @(posedge clk);
      model_step();
      chk_en = 1;
    end
  endtask

  task automatic knobs(input logic [N-1:0] m, input int rq, input int kp,
                       input int cg, input int ht, input bit fx);
    req_mask   = m;
    req_pct    = rq;
    keep_pct   = kp;
    chg_pct    = cg;
    hit_pct    = ht;
    fixed_addr = fx;
  endtask

  initial begin
    reset          = 1'b1;
    rq_valid       = '0;
    llc_data_valid = 1'b0;
    llc_data       = '0;
    for (int i = 0; i < N; i++) ra[i] = '0;
    base[0] = 64'h1000;
    base[1] = 64'h2000;
    base[2] = 64'h3000;
    model_reset();
    knobs('0, 0, 0, 0, 0, 1);
    run(3, 1);

    // single requester, LLC always hits
    knobs(3'b001, 100, 0, 0, 100, 1);
    run(12, 0);

    // all requesters held high: strict rotation
    base[0] = 64'h40;
    base[1] = 64'h80;
    base[2] = 64'hC0;
    knobs(3'b111, 100, 100, 0, 100, 1);
    run(40, 0);
    knobs('0, 0, 0, 0, 100, 1);
    run(8, 0);
    rq_valid = '0;
    run(4, 0);

    // long miss on requester 1, then hit
    base[1] = 64'h2000;
    knobs(3'b010, 100, 0, 0, 0, 1);
    run(22, 0);
    knobs('0, 0, 0, 0, 100, 1);
    run(6, 0);

    // LLC never hits: timeout goes sticky, reset clears, grant to 0 next
    knobs(3'b111, 100, 100, 50, 0, 1);
    run(30, 0);
    run(1, 1);
    knobs(3'b111, 100, 100, 0, 100, 1);
    run(12, 0);

    // random traffic, address churn mid-wait, spurious LLC valids
    for (int r = 0; r < 6; r++) begin
      knobs(3'b111, 40, 20, 30, 40 + 10 * r, 0);
      run(500, 0);
      run(1, 1);
    end
    run(5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
